// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data accesses have priority; each grant is held until mem_ready or timeout.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t        state_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic          dm_pending;
    logic          if_pending;

    // A requester still asserting in its own ack cycle must not be re-granted.
    assign dm_pending = (dm_read | dm_write) & ~dm_ack;
    assign if_pending = if_req & ~if_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ack       <= 1'b0;
            dm_ack       <= 1'b0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            err          <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (dm_pending) begin
                        state_reg    <= DATA;
                        mem_req      <= 1'b1;
                        mem_we       <= dm_write;
                        mem_addr     <= dm_addr;
                        mem_wdata    <= dm_wdata;
                        wait_cnt_reg <= '0;
                    end else if (if_pending) begin
                        state_reg    <= FETCH;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        wait_cnt_reg <= '0;
                    end
                end
                DATA, FETCH: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        state_reg <= IDLE;
                        if (state_reg == DATA) begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else if (wait_cnt_reg == TMO) begin
                        // Abort: ack the owner with zero data and flag the error.
                        mem_req   <= 1'b0;
                        state_reg <= IDLE;
                        err       <= 1'b1;
                        if (state_reg == DATA) begin
                            dm_rdata <= '0;
                            dm_ack   <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ack   <= 1'b1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout so abort paths are reachable.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && mem_req && mem_ready) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        checks++; if ({mem_req, mem_we, if_ack, dm_ack, err} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_ack, dm_ack, err}); end
        checks++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin errors++;
            $display("FAIL reset_data: got %h %h %h %h want all 0", mem_addr, mem_wdata, if_rdata, dm_rdata); end
        rst_n = 1'b1;
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++;
            $display("FAIL reset_idle: mem_req got %b want 0", mem_req); end
        $display("reset: done");
    endtask

    task automatic test_fetch();
        mem_ready = 1; mem_rdata = 32'h0051_0093; if_req = 1; if_addr = 32'h10;
        tick();
        checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin errors++;
            $display("FAIL fetch_grant: req=%b we=%b addr=%h want 1 0 00000010", mem_req, mem_we, mem_addr); end
        tick();
        checks++; if ({mem_req, if_ack, err, dm_ack} !== 4'b0100) begin errors++;
            $display("FAIL fetch_ack: req/ack/err/dm_ack got %b want 0100", {mem_req, if_ack, err, dm_ack}); end
        checks++; if (if_rdata !== 32'h0051_0093) begin errors++;
            $display("FAIL fetch_rdata: got %h want 00510093", if_rdata); end
        // if_req stays high through its ack cycle; it must not be re-granted.
        tick();
        checks++; if ({mem_req, if_ack} !== 2'b00) begin errors++;
            $display("FAIL fetch_mask: req/ack got %b want 00", {mem_req, if_ack}); end
        if_req = 0;
        tick();
        $display("fetch: addr=%h rdata=%h", 32'h10, if_rdata);
    endtask

    task automatic test_simultaneous();
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        if_req = 1; if_addr = 32'h20; dm_write = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        tick();
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin errors++;
            $display("FAIL simul_write: req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if ({dm_ack, if_ack, mem_req} !== 3'b100) begin errors++;
            $display("FAIL simul_dm_ack: dm/if/req got %b want 100", {dm_ack, if_ack, mem_req}); end
        dm_write = 0;
        tick();
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF}) begin errors++;
            $display("FAIL simul_fetch: req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if ({if_ack, dm_ack, if_rdata} !== {1'b1, 1'b0, 32'h1111_2222}) begin errors++;
            $display("FAIL simul_if_ack: if=%b dm=%b rdata=%h want 1 0 11112222", if_ack, dm_ack, if_rdata); end
        if_req = 0; mem_ready = 0;
        tick();
        $display("simultaneous: write then fetch done");
    endtask

    task automatic test_wait_states();
        int start_cnt;
        start_cnt = done_cnt;
        mem_ready = 0; mem_rdata = 32'hCAFE_F00D; dm_read = 1; dm_addr = 32'h200;
        tick();
        checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin errors++;
            $display("FAIL wait_grant: req=%b we=%b addr=%h", mem_req, mem_we, mem_addr); end
        dm_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({mem_req, dm_ack, err, mem_addr} !== {3'b100, 32'h200}) begin errors++;
                $display("FAIL wait_hold%0d: req=%b ack=%b err=%b addr=%h", i, mem_req, dm_ack, err, mem_addr); end
        end
        mem_ready = 1;
        tick();
        checks++; if ({dm_ack, err, mem_req, dm_rdata} !== {3'b100, 32'hCAFE_F00D}) begin errors++;
            $display("FAIL wait_ack: ack=%b err=%b req=%b rdata=%h", dm_ack, err, mem_req, dm_rdata); end
        dm_read = 0; mem_ready = 0;
        tick(); tick();
        checks++; if (done_cnt - start_cnt !== 1) begin errors++;
            $display("FAIL wait_count: got %0d transactions want 1", done_cnt - start_cnt); end
        $display("wait_states: rdata=%h", dm_rdata);
    endtask

    task automatic test_timeout();
        mem_ready = 0; mem_rdata = 32'h1234_5678; if_req = 1; if_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({mem_req, if_ack, err} !== 3'b100) begin errors++;
                $display("FAIL timeout_hold%0d: req/ack/err got %b want 100", i, {mem_req, if_ack, err}); end
        end
        tick();
        checks++; if ({mem_req, if_ack, err, if_rdata} !== {3'b011, 32'h0}) begin errors++;
            $display("FAIL timeout_abort: req=%b ack=%b err=%b rdata=%h", mem_req, if_ack, err, if_rdata); end
        if_req = 0;
        tick();
        checks++; if ({mem_req, if_ack, err} !== 3'b000) begin errors++;
            $display("FAIL timeout_idle: req/ack/err got %b want 000", {mem_req, if_ack, err}); end
        $display("timeout: aborted after 5 request cycles");
    endtask

    task automatic test_timeout_edge();
        mem_ready = 0; mem_rdata = 32'hA5A5_0001; dm_read = 1; dm_addr = 32'h80;
        for (int i = 0; i < 5; i++) tick();
        // Wait counter now equals the limit: ready here is a normal completion.
        mem_ready = 1;
        tick();
        checks++; if ({dm_ack, err, dm_rdata} !== {2'b10, 32'hA5A5_0001}) begin errors++;
            $display("FAIL timeout_edge: ack=%b err=%b rdata=%h", dm_ack, err, dm_rdata); end
        dm_read = 0; mem_ready = 0;
        tick();
        $display("timeout_edge: completed at limit");
    endtask

    task automatic test_reset_mid();
        mem_ready = 0; dm_write = 1; dm_addr = 32'h500; dm_wdata = 32'h5555_AAAA;
        tick();
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'h500}) begin errors++;
            $display("FAIL rstmid_grant: req=%b we=%b addr=%h", mem_req, mem_we, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b00, 64'h0}) begin errors++;
            $display("FAIL rstmid_async: req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata); end
        dm_write = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({mem_req, dm_ack, if_ack, err} !== 4'b0000) begin errors++;
                $display("FAIL rstmid_quiet%0d: req/dm/if/err got %b want 0000", i, {mem_req, dm_ack, if_ack, err}); end
        end
        $display("reset_mid: outputs cleared");
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_wait_states();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
